fft_reorder_buffer: RTL and testbench

// Parametrised ping-pong frame buffer for streaming FFTs of length N = 2**LOG2_N.
// It accepts indexed complex samples (valid/i/q/index/last) and stores one frame per bank.
// It replays each complete frame in natural or bit-reversed order, one sample per cycle.
// It sits in front of a radix-2 FFT core, or behind one to restore natural order.

---
 rtl/fft_reorder_buffer.sv | 225 ++++++++++++++++++++++
 tb/tb_fft_reorder_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_buffer.sv
// Ping-pong frame buffer for streaming radix-2 FFTs: stores indexed complex samples
// one frame per bank and replays each complete frame in natural or bit-reversed order.
module fft_reorder_buffer #(
    parameter int LOG2_N      = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int BIT_REVERSE = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Input_valid,
    input  logic [DATA_WIDTH-1:0] Input_i,
    input  logic [DATA_WIDTH-1:0] Input_q,
    input  logic [LOG2_N-1:0]     Input_index,
    input  logic                  Input_last,
    output logic                  Output_valid,
    output logic [DATA_WIDTH-1:0] Output_i,
    output logic [DATA_WIDTH-1:0] Output_q,
    output logic [LOG2_N-1:0]     Output_index,
    output logic                  Output_last,
    output logic                  Error_input_overflow,
    output logic                  Error_frame_length
);
    localparam int N = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] K_ZERO   = {LOG2_N{1'b0}};
    localparam logic [LOG2_N-1:0] K_LAST   = {LOG2_N{1'b1}};
    localparam logic [LOG2_N-1:0] K_ONE    = {{(LOG2_N-1){1'b0}}, 1'b1};
    localparam logic [LOG2_N:0]   CNT_ZERO = {(LOG2_N+1){1'b0}};
    localparam logic [LOG2_N:0]   CNT_ONE  = {{LOG2_N{1'b0}}, 1'b1};
    localparam logic [LOG2_N:0]   CNT_FULL = {1'b1, {LOG2_N{1'b0}}};

    typedef enum logic {RD_IDLE = 1'b0, RD_READ = 1'b1} rd_state_e;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
        logic [LOG2_N-1:0] r;
        for (int b = 0; b < LOG2_N; b++) begin
            r[b] = a[LOG2_N-1-b];
        end
        return r;
    endfunction

    logic [2*DATA_WIDTH-1:0] mem [0:2*N-1];
    logic [2*DATA_WIDTH-1:0] rd_data_q;

    rd_state_e             rd_state_q, rd_state_d;
    logic [LOG2_N-1:0]     k_q, k_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [LOG2_N:0]       wr_count_q, wr_count_d;
    logic                  drop_q, drop_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic [LOG2_N-1:0]     rd_index_q, rd_index_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_i_q, out_i_d;
    logic [DATA_WIDTH-1:0] out_q_q, out_q_d;
    logic [LOG2_N-1:0]     out_index_q, out_index_d;
    logic                  out_last_q, out_last_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_len_q, err_len_d;

    logic                  rd_en_s, release_s, frame_start_s, bank_busy_s, wr_en_s;
    logic [LOG2_N-1:0]     rd_addr_s;
    logic [LOG2_N:0]       wr_addr_s, rd_ram_addr_s;

    // Reader FSM, bank flags and write-side acceptance/overflow logic.
    always_comb begin
        rd_state_d  = rd_state_q;
        k_d         = k_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        wr_count_d  = wr_count_q;
        drop_d      = drop_q;
        err_ovf_d   = 1'b0;
        err_len_d   = 1'b0;
        wr_en_s     = 1'b0;

        rd_en_s       = (rd_state_q == RD_READ);
        release_s     = rd_en_s && (k_q == K_LAST);
        rd_addr_s     = (BIT_REVERSE != 0) ? bitrev(k_q) : k_q;
        rd_ram_addr_s = {rd_bank_q, rd_addr_s};
        wr_addr_s     = {wr_bank_q, Input_index};

        case (rd_state_q)
            RD_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    rd_state_d = RD_READ;
                    k_d        = K_ZERO;
                end else begin
                    rd_state_d = RD_IDLE;
                end
            end
            RD_READ: begin
                if (k_q == K_LAST) begin
                    rd_state_d = RD_IDLE;
                    rd_bank_d  = ~rd_bank_q;
                    k_d        = K_ZERO;
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
                k_d        = K_ZERO;
            end
        endcase

        // Release is applied before the write-side set so a same-bank set wins.
        if (release_s) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end else begin
            bank_full_d = bank_full_q;
        end

        frame_start_s = (wr_count_q == CNT_ZERO) && !drop_q;
        bank_busy_s   = bank_full_q[wr_bank_q] && !(release_s && (rd_bank_q == wr_bank_q));

        if (Input_valid) begin
            if (drop_q) begin
                drop_d = !Input_last;
            end else if (frame_start_s && bank_busy_s) begin
                err_ovf_d = 1'b1;
                drop_d    = !Input_last;
            end else begin
                wr_en_s = Rst;
                if (Input_last) begin
                    bank_full_d[wr_bank_q] = 1'b1;
                    wr_bank_d              = ~wr_bank_q;
                    wr_count_d             = CNT_ZERO;
                    err_len_d              = ((wr_count_q + CNT_ONE) != CNT_FULL);
                end else begin
                    wr_count_d = wr_count_q + CNT_ONE;
                end
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Read pipeline (RAM stage, then output register holding data between frames).
    always_comb begin
        rd_valid_d  = rd_en_s;
        rd_last_d   = release_s;
        rd_index_d  = rd_index_q;
        out_valid_d = rd_valid_q;
        out_last_d  = rd_valid_q && rd_last_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_index_d = out_index_q;
        if (rd_en_s) begin
            rd_index_d = rd_addr_s;
        end else begin
            rd_index_d = rd_index_q;
        end
        if (rd_valid_q) begin
            out_i_d     = rd_data_q[2*DATA_WIDTH-1:DATA_WIDTH];
            out_q_d     = rd_data_q[DATA_WIDTH-1:0];
            out_index_d = rd_index_q;
        end else begin
            out_i_d     = out_i_q;
            out_q_d     = out_q_q;
            out_index_d = out_index_q;
        end
    end

    // Simple dual-port sample RAM: one write port, one synchronous read port.
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= {Input_i, Input_q};
        end
        if (rd_en_s) begin
            rd_data_q <= mem[rd_ram_addr_s];
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            rd_state_q  <= RD_IDLE;
            k_q         <= K_ZERO;
            bank_full_q <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_count_q  <= CNT_ZERO;
            drop_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_index_q  <= K_ZERO;
            out_valid_q <= 1'b0;
            out_i_q     <= {DATA_WIDTH{1'b0}};
            out_q_q     <= {DATA_WIDTH{1'b0}};
            out_index_q <= K_ZERO;
            out_last_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            k_q         <= k_d;
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_count_q  <= wr_count_d;
            drop_q      <= drop_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            rd_index_q  <= rd_index_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            err_ovf_q   <= err_ovf_d;
            err_len_q   <= err_len_d;
        end
    end

    assign Output_valid         = out_valid_q;
    assign Output_i             = out_i_q;
    assign Output_q             = out_q_q;
    assign Output_index         = out_index_q;
    assign Output_last          = out_last_q;
    assign Error_input_overflow = err_ovf_q;
    assign Error_frame_length   = err_len_q;
endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Scoreboard bench: drives two instances (bit-reversed and natural order) with the
// same stimulus and compares every output sample against queued expectations.
module tb_fft_reorder_buffer;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    logic        in_valid = 1'b0;
    logic [15:0] in_i = 16'd0;
    logic [15:0] in_q = 16'd0;
    logic [4:0]  in_idx = 5'd0;
    logic        in_last = 1'b0;

    logic        ov [2];
    logic [15:0] oi [2];
    logic [15:0] oq [2];
    logic [4:0]  oidx [2];
    logic        olast [2];
    logic        oovf [2];
    logic        oflen [2];

    fft_reorder_buffer #(.LOG2_N(5), .DATA_WIDTH(16), .BIT_REVERSE(1)) dut_br (
        .Clk(Clk), .Rst(Rst), .Input_valid(in_valid), .Input_i(in_i), .Input_q(in_q),
        .Input_index(in_idx), .Input_last(in_last), .Output_valid(ov[0]), .Output_i(oi[0]),
        .Output_q(oq[0]), .Output_index(oidx[0]), .Output_last(olast[0]),
        .Error_input_overflow(oovf[0]), .Error_frame_length(oflen[0]));

    fft_reorder_buffer #(.LOG2_N(5), .DATA_WIDTH(16), .BIT_REVERSE(0)) dut_nat (
        .Clk(Clk), .Rst(Rst), .Input_valid(in_valid), .Input_i(in_i), .Input_q(in_q),
        .Input_index(in_idx), .Input_last(in_last), .Output_valid(ov[1]), .Output_i(oi[1]),
        .Output_q(oq[1]), .Output_index(oidx[1]), .Output_last(olast[1]),
        .Error_input_overflow(oovf[1]), .Error_frame_length(oflen[1]));

    typedef struct packed {
        logic [4:0]  idx;
        logic [15:0] i;
        logic [15:0] q;
        logic        last;
    } exp_t;

    exp_t        q_br[$];
    exp_t        q_nat[$];
    logic [31:0] img [0:1][0:31];
    int          tb_bank = 0;
    int          tests = 0;
    int          fails = 0;
    int          run_len [2];
    int          gap_len [2];
    int          gap1_cnt [2];
    int          ovf_cnt [2];
    int          flen_cnt [2];
    bit          prev_v [2];
    bit          seen_run [2];
    bit          chk_len = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] brev(input logic [4:0] a);
        logic [4:0] r;
        for (int b = 0; b < 5; b++) r[b] = a[4-b];
        return r;
    endfunction

    // Output monitor: scoreboard pop, frame run length, inter-frame gaps, error pulses.
    always @(negedge Clk) begin : mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (ov[d]) begin
                if (!prev_v[d] && seen_run[d] && gap_len[d] == 1) gap1_cnt[d]++;
                run_len[d]++;
                gap_len[d] = 0;
                if ((d == 0 ? q_br.size() : q_nat.size()) == 0) begin
                    check($sformatf("d%0d_unexpected_output", d), 32'(ov[d]), 32'd0);
                end else begin
                    if (d == 0) e = q_br.pop_front();
                    else e = q_nat.pop_front();
                    check($sformatf("d%0d_index", d), 32'(oidx[d]), 32'(e.idx));
                    check($sformatf("d%0d_i", d), 32'(oi[d]), 32'(e.i));
                    check($sformatf("d%0d_q", d), 32'(oq[d]), 32'(e.q));
                    check($sformatf("d%0d_last", d), 32'(olast[d]), 32'(e.last));
                end
            end else begin
                if (prev_v[d]) begin
                    if (chk_len) check($sformatf("d%0d_run_len", d), 32'(run_len[d]), 32'd32);
                    seen_run[d] = 1'b1;
                    run_len[d] = 0;
                end
                gap_len[d]++;
            end
            if (oovf[d]) ovf_cnt[d]++;
            if (oflen[d]) flen_cnt[d]++;
            prev_v[d] = ov[d];
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic drive(input logic [4:0] idx, input logic [15:0] di, input logic [15:0] dq,
                         input logic last);
        in_valid = 1'b1;
        in_idx   = idx;
        in_i     = di;
        in_q     = dq;
        in_last  = last;
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_frame(input int b);
        exp_t e;
        for (int k = 0; k < 32; k++) begin
            e.idx = brev(5'(k));
            {e.i, e.q} = img[b][e.idx];
            e.last = (k == 31);
            q_br.push_back(e);
            e.idx = 5'(k);
            {e.i, e.q} = img[b][k];
            q_nat.push_back(e);
        end
    endtask

    task automatic send_frame(input int nsamp, input bit rnd, input int max_gap,
                              input bit accept, input bit with_last);
        logic [15:0] di, dq;
        for (int j = 0; j < nsamp; j++) begin
            if (j > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
            di = rnd ? 16'($urandom) : 16'(j);
            dq = rnd ? 16'($urandom) : 16'(-j);
            if (accept) img[tb_bank][j] = {di, dq};
            drive(5'(j), di, dq, with_last && (j == nsamp - 1));
        end
        if (accept) begin
            push_frame(tb_bank);
            tb_bank ^= 1;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_valid", tag, d), 32'(ov[d]), 32'd0);
            check($sformatf("%s_d%0d_i", tag, d), 32'(oi[d]), 32'd0);
            check($sformatf("%s_d%0d_q", tag, d), 32'(oq[d]), 32'd0);
            check($sformatf("%s_d%0d_index", tag, d), 32'(oidx[d]), 32'd0);
            check($sformatf("%s_d%0d_last", tag, d), 32'(olast[d]), 32'd0);
            check($sformatf("%s_d%0d_ovf", tag, d), 32'(oovf[d]), 32'd0);
            check($sformatf("%s_d%0d_flen", tag, d), 32'(oflen[d]), 32'd0);
        end
    endtask

    task automatic check_state(input string tag, input int exp_ovf, input int exp_flen);
        check({tag, "_qbr_empty"}, 32'(q_br.size()), 32'd0);
        check({tag, "_qnat_empty"}, 32'(q_nat.size()), 32'd0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_ovf_cnt", tag, d), 32'(ovf_cnt[d]), 32'(exp_ovf));
            check($sformatf("%s_d%0d_flen_cnt", tag, d), 32'(flen_cnt[d]), 32'(exp_flen));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            run_len[d] = 0; gap_len[d] = 0; gap1_cnt[d] = 0;
            ovf_cnt[d] = 0; flen_cnt[d] = 0; prev_v[d] = 1'b0; seen_run[d] = 1'b0;
        end
        for (int b = 0; b < 2; b++)
            for (int j = 0; j < 32; j++) img[b][j] = 32'd0;

        // Reset state
        Rst = 1'b0;
        idle(3);
        check_zero("reset");
        Rst = 1'b1;
        idle(2);
        chk_len = 1'b1;

        // Ramp frame, reader idle: latency 3 edges after the last sample
        send_frame(32, 1'b0, 0, 1'b1, 1'b1);
        check("t1_lat_e0", 32'(ov[0]), 32'd0);
        idle(1);
        check("t1_lat_e1", 32'(ov[0]), 32'd0);
        idle(1);
        check("t1_lat_e2", 32'(ov[0]), 32'd0);
        idle(1);
        check("t1_lat_e3_br", 32'(ov[0]), 32'd1);
        check("t1_lat_e3_nat", 32'(ov[1]), 32'd1);
        idle(40);
        check_state("t1", 0, 0);

        // Random sample gaps and frame gaps
        for (int f = 0; f < 4; f++) begin
            send_frame(32, 1'b1, 5, 1'b1, 1'b1);
            idle($urandom_range(32, 64));
        end
        idle(40);
        check_state("t2", 0, 0);

        // Three back-to-back frames via release bypass, fourth overflows
        gap1_cnt[0] = 0;
        gap1_cnt[1] = 0;
        send_frame(32, 1'b1, 0, 1'b1, 1'b1);
        send_frame(32, 1'b1, 0, 1'b1, 1'b1);
        send_frame(32, 1'b1, 0, 1'b1, 1'b1);
        send_frame(32, 1'b1, 0, 1'b0, 1'b1);
        idle(120);
        check("t3_gap1_br", 32'(gap1_cnt[0]), 32'd2);
        check("t3_gap1_nat", 32'(gap1_cnt[1]), 32'd2);
        check_state("t4_drop", 1, 0);
        send_frame(32, 1'b1, 0, 1'b1, 1'b1);
        idle(50);
        check_state("t4_after", 1, 0);

        // Short frame keeps stale tail entries, bank toggles normally
        send_frame(20, 1'b1, 0, 1'b1, 1'b1);
        idle(50);
        check_state("t5_short", 1, 1);
        send_frame(32, 1'b1, 0, 1'b1, 1'b1);
        idle(50);
        check_state("t5_next", 1, 1);

        // Reset mid-frame
        send_frame(10, 1'b1, 0, 1'b0, 1'b0);
        Rst = 1'b0;
        idle(1);
        check_zero("t6_midframe");
        Rst = 1'b1;
        tb_bank = 0;
        idle(2);
        send_frame(32, 1'b1, 0, 1'b1, 1'b1);
        idle(50);
        check_state("t6_frame1", 1, 1);

        // Reset mid-readout
        send_frame(32, 1'b1, 0, 1'b1, 1'b1);
        for (int c = 0; c < 20 && !ov[0]; c++) idle(1);
        check("t6_readout_started", 32'(ov[0]), 32'd1);
        idle(10);
        chk_len = 1'b0;
        Rst = 1'b0;
        idle(1);
        check_zero("t6_midreadout");
        q_br.delete();
        q_nat.delete();
        Rst = 1'b1;
        tb_bank = 0;
        idle(2);
        chk_len = 1'b1;
        send_frame(32, 1'b1, 0, 1'b1, 1'b1);
        idle(50);
        check_state("t6_frame2", 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
